// File: rtl/branch_unit_pkg.sv
// Shared encodings for the branch unit: branch-type codes and FSM state encodings.
package branch_unit_pkg;

    localparam logic [2:0] BR_NONE  = 3'd0;
    localparam logic [2:0] BR_BEQ   = 3'd1;
    localparam logic [2:0] BR_BIOAL = 3'd2;
    localparam logic [2:0] BR_J     = 3'd3;
    localparam logic [2:0] BR_JAL   = 3'd4;
    localparam logic [2:0] BR_JR    = 3'd5;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

endpackage

// File: rtl/branch_unit_target.sv
// Combinational branch/jump target computation for the ID-stage instruction.
module branch_target
    import branch_unit_pkg::*;
(
    input  logic [2:0]  id_br_type,
    input  logic [31:0] id_pc,
    input  logic [15:0] id_imm16,
    input  logic [25:0] id_index26,
    input  logic [31:0] id_rs_val,
    output logic [31:0] target
);

    logic [31:0] pc4;

    always_comb begin
        pc4    = id_pc + 32'd4;
        target = pc4;
        case (id_br_type)
            BR_BEQ, BR_BIOAL: target = pc4 + {{14{id_imm16[15]}}, id_imm16, 2'b00};
            BR_J, BR_JAL:     target = {pc4[31:28], id_index26, 2'b00};
            BR_JR:            target = id_rs_val;
            default:          target = pc4;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// ID-stage branch resolution, fetch PC ownership and link-write staging.
// Optional statistics counters are enabled with the BRANCH_UNIT_STATS_EN macro.
//
// state   | meaning
// ST_RUN  | pc advances or redirects whenever fetch is ready
// ST_PEND | a taken target waits in pend_target for fetch to become ready
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [4:0]  LINK_REG = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        if_ready,
    input  logic        id_valid,
    input  logic [2:0]  id_br_type,
    input  logic [31:0] id_pc,
    input  logic [15:0] id_imm16,
    input  logic [25:0] id_index26,
    input  logic [31:0] id_rs_val,
    input  logic        cmp_zero,
    input  logic        cmp_overflow,
    output logic [31:0] pc,
    output logic        redirect,
    output logic        link_we,
    output logic [4:0]  link_addr,
    output logic [31:0] link_data
`ifdef BRANCH_UNIT_STATS_EN
    ,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_taken
`endif
);

    state_t      state, state_next;
    logic [31:0] pend_target, pend_next;
    logic [31:0] pc_next;
    logic        redirect_next;
    logic [31:0] target;
    logic        resolve;
    logic        taken;

    branch_target u_target (
        .id_br_type (id_br_type),
        .id_pc      (id_pc),
        .id_imm16   (id_imm16),
        .id_index26 (id_index26),
        .id_rs_val  (id_rs_val),
        .target     (target)
    );

    always_comb begin
        resolve = id_valid && !stall && (id_br_type != BR_NONE);
        taken   = 1'b0;
        if (resolve) begin
            case (id_br_type)
                BR_BEQ:              taken = cmp_zero;
                BR_BIOAL:            taken = cmp_overflow;
                BR_J, BR_JAL, BR_JR: taken = 1'b1;
                default:             taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            redirect    <= 1'b0;
            pend_target <= 32'd0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            redirect    <= redirect_next;
            pend_target <= pend_next;
        end
    end

    // A taken resolution in the same cycle PEND drains is younger, so it wins over pend_target.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        pend_next     = pend_target;
        redirect_next = 1'b0;
        if (!stall) begin
            case (state)
                ST_RUN: begin
                    if (if_ready) begin
                        if (taken) begin
                            pc_next       = target;
                            redirect_next = 1'b1;
                        end else begin
                            pc_next = pc + 32'd4;
                        end
                    end else if (taken) begin
                        pend_next  = target;
                        state_next = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (if_ready) begin
                        pc_next       = taken ? target : pend_target;
                        redirect_next = 1'b1;
                        state_next    = ST_RUN;
                    end else if (taken) begin
                        pend_next = target;
                    end
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_comb begin
        link_we   = id_valid && !stall &&
                    ((id_br_type == BR_JAL) || ((id_br_type == BR_BIOAL) && cmp_overflow));
        link_addr = link_we ? LINK_REG : 5'd0;
        link_data = id_pc + 32'd8;
    end

`ifdef BRANCH_UNIT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_resolved <= 32'd0;
            stat_taken    <= 32'd0;
        end else begin
            if (resolve && (stat_resolved != 32'hFFFF_FFFF))
                stat_resolved <= stat_resolved + 32'd1;
            if (taken && (stat_taken != 32'hFFFF_FFFF))
                stat_taken <= stat_taken + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit: sequential fetch, branches, PEND backpressure, stall, reset.
module tb_branch_unit;
    import branch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, if_ready, id_valid;
    logic [2:0]  id_br_type;
    logic [31:0] id_pc, id_rs_val;
    logic [15:0] id_imm16;
    logic [25:0] id_index26;
    logic        cmp_zero, cmp_overflow;
    logic [31:0] pc, link_data;
    logic        redirect, link_we;
    logic [4:0]  link_addr;
`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] stat_resolved, stat_taken;
`endif

    int n_pass = 0;
    int n_total = 0;

    branch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .if_ready     (if_ready),
        .id_valid     (id_valid),
        .id_br_type   (id_br_type),
        .id_pc        (id_pc),
        .id_imm16     (id_imm16),
        .id_index26   (id_index26),
        .id_rs_val    (id_rs_val),
        .cmp_zero     (cmp_zero),
        .cmp_overflow (cmp_overflow),
        .pc           (pc),
        .redirect     (redirect),
        .link_we      (link_we),
        .link_addr    (link_addr),
        .link_data    (link_data)
`ifdef BRANCH_UNIT_STATS_EN
        ,
        .stat_resolved (stat_resolved),
        .stat_taken    (stat_taken)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] ipc,
                         input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs,
                         input logic z, input logic ov);
        id_valid = v; id_br_type = t; id_pc = ipc; id_imm16 = imm;
        id_index26 = idx; id_rs_val = rs; cmp_zero = z; cmp_overflow = ov;
    endtask

    task automatic idle();
        drive(1'b0, BR_NONE, 32'd0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; if_ready = 1'b1;
        idle();
        step(); step();
        reset = 1'b0;

        // sequential fetch after reset
        check("reset_pc", pc, 32'h3000);
        check("reset_redirect", {31'd0, redirect}, 32'd0);
        step(); check("seq_pc1", pc, 32'h3004);
        step(); check("seq_pc2", pc, 32'h3008);
        check("seq_redirect", {31'd0, redirect}, 32'd0);

        // BEQ backwards by one word
        drive(1'b1, BR_BEQ, 32'h3004, 16'hFFFF, 26'd0, 32'd0, 1'b1, 1'b0);
        #1 check("beq_no_link", {31'd0, link_we}, 32'd0);
        step(); check("beq_taken_pc", pc, 32'h3004);
        check("beq_taken_redirect", {31'd0, redirect}, 32'd1);
        cmp_zero = 1'b0;
        step(); check("beq_nt_pc", pc, 32'h3008);
        check("beq_nt_redirect", {31'd0, redirect}, 32'd0);

        // BIOAL links and branches on overflow
        drive(1'b1, BR_BIOAL, 32'h3010, 16'h0004, 26'd0, 32'd0, 1'b0, 1'b1);
        #1 check("bioal_link_we", {31'd0, link_we}, 32'd1);
        check("bioal_link_addr", {27'd0, link_addr}, 32'd31);
        check("bioal_link_data", link_data, 32'h3018);
        step(); check("bioal_pc", pc, 32'h3024);
        check("bioal_redirect", {31'd0, redirect}, 32'd1);
        cmp_overflow = 1'b0;
        #1 check("bioal_nov_link_we", {31'd0, link_we}, 32'd0);
        check("bioal_nov_link_addr", {27'd0, link_addr}, 32'd0);
        step(); check("bioal_nov_pc", pc, 32'h3028);

        // JAL held off by fetch backpressure for three cycles
        if_ready = 1'b0;
        drive(1'b1, BR_JAL, 32'h4000_0000, 16'd0, 26'h0000C40, 32'd0, 1'b0, 1'b0);
        #1 check("jal_link_we", {31'd0, link_we}, 32'd1);
        check("jal_link_data", link_data, 32'h4000_0008);
        step(); check("pend_hold1", pc, 32'h3028);
        check("pend_redirect", {31'd0, redirect}, 32'd0);
        idle();
        step(); step(); check("pend_hold3", pc, 32'h3028);
        if_ready = 1'b1;
        step(); check("pend_drain_pc", pc, 32'h4000_3100);
        check("pend_drain_redirect", {31'd0, redirect}, 32'd1);
        step(); check("after_drain_pc", pc, 32'h4000_3104);
        check("after_drain_redirect", {31'd0, redirect}, 32'd0);

        // JR while pending replaces the older JAL target
        if_ready = 1'b0;
        drive(1'b1, BR_JAL, 32'h3000, 16'd0, 26'h40, 32'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, BR_JR, 32'h3100, 16'd0, 26'd0, 32'h0000_5003, 1'b0, 1'b0);
        #1 check("jr_no_link", {31'd0, link_we}, 32'd0);
        step(); check("jr_pend_hold", pc, 32'h4000_3104);
        idle(); if_ready = 1'b1;
        step(); check("jr_wins_pc", pc, 32'h0000_5003);
        check("jr_redirect", {31'd0, redirect}, 32'd1);

        // stall freezes PEND; BEQ resolves when stall drops
        if_ready = 1'b0;
        drive(1'b1, BR_JAL, 32'h3000, 16'd0, 26'h40, 32'd0, 1'b0, 1'b0);
        step();
        stall = 1'b1; if_ready = 1'b1;
        drive(1'b1, BR_JAL, 32'h3000, 16'd0, 26'h40, 32'd0, 1'b0, 1'b0);
        #1 check("stall_jal_no_link", {31'd0, link_we}, 32'd0);
        drive(1'b1, BR_BEQ, 32'h3000, 16'h0010, 26'd0, 32'd0, 1'b1, 1'b0);
        step(); check("stall_pc1", pc, 32'h0000_5003);
        check("stall_redirect", {31'd0, redirect}, 32'd0);
        step(); check("stall_pc2", pc, 32'h0000_5003);
        stall = 1'b0;
        step(); check("unstall_beq_pc", pc, 32'h3044);
        check("unstall_redirect", {31'd0, redirect}, 32'd1);

        // reset in PEND
        if_ready = 1'b0;
        drive(1'b1, BR_JAL, 32'h3000, 16'd0, 26'h40, 32'd0, 1'b0, 1'b0);
        step();
        reset = 1'b1; idle(); if_ready = 1'b1;
        step(); check("rst_pend_pc", pc, 32'h3000);
        check("rst_pend_redirect", {31'd0, redirect}, 32'd0);
`ifdef BRANCH_UNIT_STATS_EN
        check("rst_stat_resolved", stat_resolved, 32'd0);
        check("rst_stat_taken", stat_taken, 32'd0);
`endif
        reset = 1'b0;
        step(); check("rst_run_pc", pc, 32'h3004);
        check("rst_run_redirect", {31'd0, redirect}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- ID-stage consumer of the comparator flags (`zero`, `overflow`) for the P5 pipelined MIPS core.
- Resolves branches and jumps, owns the IF program counter and stages the link-register write request.
- Absorbs instruction-fetch backpressure with a pending-target register, so no redirect is lost while fetch is not ready.
- Delay-slot semantics: the instruction at `id_pc+4` always executes.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- LINK_REG, 5'd31, GPR index written by jal/bioal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard-unit freeze of PC and IF/ID.
- if_ready  in  1  fetch accepts the PC this cycle.
- id_valid  in  1  ID holds a real instruction (not a bubble).
- id_br_type  in  3  BR_NONE/BR_BEQ/BR_BIOAL/BR_J/BR_JAL/BR_JR.
- id_pc  in  32  PC of the ID instruction.
- id_imm16  in  16  branch offset.
- id_index26  in  26  jump index.
- id_rs_val  in  32  forwarded rs, used by jr.
- cmp_zero  in  1  comparator equal flag.
- cmp_overflow  in  1  comparator signed-add overflow flag.
- pc  out  32  current fetch PC (registered).
- redirect  out  1  registered one-cycle pulse: `pc` was just loaded non-sequentially.
- link_we  out  1  combinational GPR link-write request.
- link_addr  out  5  equals LINK_REG when `link_we` is asserted, else 0.
- link_data  out  32  `id_pc+8`.

Behaviour:
- Reset (synchronous, active-high): `pc`=RESET_PC, `redirect`=0, state=RUN, `pend_target`=0. Reset takes priority over every other input, including mid-PEND.
- Taken condition, evaluated only when `id_valid` and not `stall`; `id_br_type`=BR_NONE is never taken:
  - BEQ: taken when `cmp_zero`.
  - BIOAL: taken when `cmp_overflow`.
  - J, JAL, JR: always taken.
- Target:
  - BEQ/BIOAL: `id_pc+4 + (sext(id_imm16)<<2)`, wrap mod 2^32.
  - J/JAL: `{pc4[31:28], id_index26, 2'b00}`, where pc4 = `id_pc+4`.
  - JR: `id_rs_val`, used unaligned as-is.
- FSM states RUN and PEND. With `stall`=1, all registers hold in either state, including `pend_target`.
- RUN, `stall`=0:
  - `if_ready`=1: `pc` <= target if taken, else `pc+4`.
  - `if_ready`=0: `pc` holds; if taken, `pend_target` <= target and go to PEND.
- PEND, `stall`=0:
  - `if_ready`=1: `pc` <= `pend_target` (or the new target, if taken this same cycle); go to RUN.
  - `if_ready`=0: a new taken resolution overwrites `pend_target` (youngest wins); otherwise hold.
- `redirect` is asserted the cycle after any non-sequential load of `pc`; it is 0 otherwise.
- Link (combinational, same cycle as resolution): `link_we` = `id_valid` & !`stall` & (JAL | JR-never | (BIOAL & `cmp_overflow`)). BEQ never links.
- Latency: a branch resolved in cycle N gives `pc`=target in cycle N+1 when `if_ready`=1.

Optional Feature:
- Macro BRANCH_UNIT_STATS_EN.
- Defined: adds outputs `stat_resolved[31:0]` and `stat_taken[31:0]`.
  - `stat_resolved` counts each non-stalled valid non-NONE instruction; `stat_taken` counts each taken one.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared `macro.v` gains BR_NONE=3'd0, BR_BEQ=1, BR_BIOAL=2, BR_J=3, BR_JAL=4, BR_JR=5, and the ST_RUN/ST_PEND encodings.
- One natural sub-module: `branch_target`, purely combinational (`id_br_type`, `id_pc`, `id_imm16`, `id_index26`, `id_rs_val` -> target).

Test Plan:
1. Reset with no branches, `if_ready`=1 -> `pc` 0x3000, 0x3004, 0x3008; `redirect`=0.
2. BEQ at `id_pc`=0x3004, imm=0xFFFF, `cmp_zero`=1 -> next `pc`=0x3004, `redirect`=1 next cycle. Same stimulus with `cmp_zero`=0 -> `pc+4`, no redirect.
3. BIOAL at 0x3010, `cmp_overflow`=1 -> `link_we`=1, `link_addr`=31, `link_data`=0x3018 same cycle; target taken. With `cmp_overflow`=0 -> `link_we`=0.
4. JAL taken with `if_ready`=0 for 3 cycles -> `pc` held, state PEND; `if_ready` rises -> `pc`=target, state RUN. A second JR while in PEND -> JR target wins.
5. `stall`=1 during a valid BEQ with `cmp_zero`=1 -> `pc`, PEND state and `link_we` unchanged; BEQ resolves on the cycle `stall` falls.
6. `reset` asserted while in PEND -> `pc`=0x3000, RUN, `redirect`=0; with BRANCH_UNIT_STATS_EN, counters=0.
